store_check_sequencer: RTL

- Synthesizable hardware test sequencer that sits directly downstream of the MIPS `top`.
- Consumes the processor's store bus (memwrite, dataadr, writedata) and drives the processor's reset.
- Steps through NUM_TESTS fixed-length program windows. In each window it compares every store against an expected (address, data) pair supplied for the current test index, then records pass/fail per test.
- Used for on-board regression and as a bench-independent pass/fail reporter.

---
 rtl/store_check_defs.sv | 54 +++++
 rtl/store_expect_rom.sv | 26 ++
 rtl/store_check_sequencer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/store_check_defs.sv
// rtl/store_check_defs.sv - shared state encoding, counter sizing and expected-store table
// The optional STORE_CHECK_MISLOG_EN build uses these definitions unchanged.
package store_check_defs;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RESET_DUT = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_RECORD    = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = ST_IDLE,
        S_RESET_DUT = ST_RESET_DUT,
        S_RUN       = ST_RUN,
        S_RECORD    = ST_RECORD,
        S_DONE      = ST_DONE
    } state_t;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] data;
    } expect_t;

    function automatic int cnt_width(input int reset_cycles, input int window_cycles);
        int longest;
        longest = (reset_cycles > window_cycles) ? reset_cycles : window_cycles;
        return $clog2(longest + 1);
    endfunction

    localparam int CNTW = cnt_width(2, 100);

    // Final store of each regression program: (address, data) it must produce.
    function automatic expect_t expect_entry(input int idx);
        expect_t e;
        case (idx)
            0:       e = '{adr: 32'h0000_0014, data: 32'd21};
            1:       e = '{adr: 32'h0000_0054, data: 32'd7};
            2:       e = '{adr: 32'h70f0_0ff0, data: 32'd2};
            3:       e = '{adr: 32'h0000_0018, data: 32'd13};
            4:       e = '{adr: 32'h0000_001c, data: 32'hffff_fffe};
            5:       e = '{adr: 32'h0000_0020, data: 32'd42};
            6:       e = '{adr: 32'h0000_0024, data: 32'h8000_0000};
            7:       e = '{adr: 32'h0000_0028, data: 32'd100};
            8:       e = '{adr: 32'h0000_002c, data: 32'h1234_5678};
            9:       e = '{adr: 32'h0000_0030, data: 32'd64};
            10:      e = '{adr: 32'h0000_0034, data: 32'd1};
            11:      e = '{adr: 32'h0000_0038, data: 32'hdead_beef};
            12:      e = '{adr: 32'h0000_0000, data: 32'd3500};
            default: e = '{adr: 32'h0, data: 32'h0};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_expect_rom.sv
// rtl/store_expect_rom.sv - combinational test_idx -> expected (address, data) table
// Sits beside store_check_sequencer and feeds its exp_adr/exp_data inputs.
module store_expect_rom
    import store_check_defs::*;
#(
    parameter int NUM_TESTS = 13,
    parameter int IDXW      = 4
) (
    input  logic [IDXW-1:0] test_idx,
    output logic [31:0]     exp_adr,
    output logic [31:0]     exp_data
);

    expect_t entry;

    always_comb begin
        entry = '{adr: 32'h0, data: 32'h0};
        if (int'(test_idx) < NUM_TESTS) begin
            entry = expect_entry(int'(test_idx));
        end
    end

    assign exp_adr  = entry.adr;
    assign exp_data = entry.data;

endmodule

// File: rtl/store_check_sequencer.sv
// rtl/store_check_sequencer.sv - resets the CPU per test window and scores its stores
// Define STORE_CHECK_MISLOG_EN to add the mismatch logging outputs.
module store_check_sequencer
    import store_check_defs::*;
#(
    parameter int NUM_TESTS     = 13,
    parameter int RESET_CYCLES  = 2,
    parameter int WINDOW_CYCLES = 100,
    parameter int IDXW          = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 memwrite,
    input  logic [31:0]          dataadr,
    input  logic [31:0]          writedata,
    input  logic [31:0]          exp_adr,
    input  logic [31:0]          exp_data,
    output logic                 cpu_reset,
    output logic [IDXW-1:0]      test_idx,
    output logic                 busy,
    output logic                 done,
    output logic [IDXW:0]        pass_count,
`ifdef STORE_CHECK_MISLOG_EN
    output logic [15:0]          mis_count,
    output logic                 first_mis_valid,
    output logic [31:0]          first_mis_adr,
    output logic [31:0]          first_mis_data,
    output logic [IDXW-1:0]      first_mis_idx,
`endif
    output logic [NUM_TESTS-1:0] pass_vec
);

    localparam int CW = cnt_width(RESET_CYCLES, WINDOW_CYCLES);
    localparam logic [CW-1:0]   RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0]   WIN_LAST = CW'(WINDOW_CYCLES - 1);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_TESTS - 1);

    state_t                state_q;
    logic [CW-1:0]         cnt_q;
    logic                  hit_q;
    logic                  cpu_reset_q;
    logic                  busy_q;
    logic                  done_q;
    logic [IDXW-1:0]       test_idx_q;
    logic [IDXW:0]         pass_count_q;
    logic [NUM_TESTS-1:0]  pass_vec_q;
    logic                  adr_data_eq;
    logic                  match;

    assign adr_data_eq = (dataadr == exp_adr) && (writedata == exp_data);
    assign match       = memwrite && adr_data_eq;

`ifdef STORE_CHECK_MISLOG_EN
    logic [15:0]     mis_count_q;
    logic            first_mis_valid_q;
    logic [31:0]     first_mis_adr_q;
    logic [31:0]     first_mis_data_q;
    logic [IDXW-1:0] first_mis_idx_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            mis_count_q       <= '0;
            first_mis_valid_q <= 1'b0;
            first_mis_adr_q   <= '0;
            first_mis_data_q  <= '0;
            first_mis_idx_q   <= '0;
        end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
            mis_count_q       <= '0;
            first_mis_valid_q <= 1'b0;
            first_mis_adr_q   <= '0;
            first_mis_data_q  <= '0;
            first_mis_idx_q   <= '0;
        end else if (state_q == S_RUN && memwrite && !adr_data_eq) begin
            if (mis_count_q != 16'hffff) begin
                mis_count_q <= mis_count_q + 16'd1;
            end
            if (!first_mis_valid_q) begin
                first_mis_valid_q <= 1'b1;
                first_mis_adr_q   <= dataadr;
                first_mis_data_q  <= writedata;
                first_mis_idx_q   <= test_idx_q;
            end
        end
    end

    assign mis_count       = mis_count_q;
    assign first_mis_valid = first_mis_valid_q;
    assign first_mis_adr   = first_mis_adr_q;
    assign first_mis_data  = first_mis_data_q;
    assign first_mis_idx   = first_mis_idx_q;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            hit_q        <= 1'b0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            test_idx_q   <= '0;
            pass_count_q <= '0;
            pass_vec_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q      <= S_RESET_DUT;
                        cnt_q        <= '0;
                        hit_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        test_idx_q   <= '0;
                        pass_count_q <= '0;
                        pass_vec_q   <= '0;
                    end
                end
                S_RESET_DUT: begin
                    if (cnt_q == RST_LAST) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        hit_q       <= 1'b0;
                        cpu_reset_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RUN: begin
                    // Sticky: once the expected store is seen the window still runs to term.
                    if (match) begin
                        hit_q <= 1'b1;
                    end
                    if (cnt_q == WIN_LAST) begin
                        state_q     <= S_RECORD;
                        cnt_q       <= '0;
                        cpu_reset_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RECORD: begin
                    for (int i = 0; i < NUM_TESTS; i++) begin
                        if (test_idx_q == IDXW'(i)) begin
                            pass_vec_q[i] <= hit_q;
                        end
                    end
                    pass_count_q <= pass_count_q + {{IDXW{1'b0}}, hit_q};
                    if (test_idx_q == IDX_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_RESET_DUT;
                        test_idx_q <= test_idx_q + 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    cnt_q       <= '0;
                    cpu_reset_q <= 1'b1;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_reset  = cpu_reset_q;
    assign test_idx   = test_idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass_count = pass_count_q;
    assign pass_vec   = pass_vec_q;

endmodule
